keypad_scanner: RTL and testbench

//  Scans the 4x3 matrix keypad and produces the debounced one-hot column/row key code consumed
//  by vendingmachine (coluna_in/linha_in). Drives one row at a time and samples the columns.

---
 rtl/keypad_scanner_if.sv | 24 ++
 rtl/keypad_scanner.sv | 198 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: raw column sense in, row drive and debounced key code out.
interface keypad_scanner_if;
    logic [2:0] col_sense_in;
    logic [3:0] row_drive_out;
    logic [2:0] coluna_out;
    logic [3:0] linha_out;
    logic       key_valid_out;
    logic       key_strobe_out;
    logic [3:0] key_code_out;

    // scanner side
    modport master (
        input  col_sense_in,
        output row_drive_out, coluna_out, linha_out,
               key_valid_out, key_strobe_out, key_code_out
    );

    // keypad / consumer side
    modport slave (
        output col_sense_in,
        input  row_drive_out, coluna_out, linha_out,
               key_valid_out, key_strobe_out, key_code_out
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: row-at-a-time drive, per-sweep classification,
// sweep-granular debounce FSM with latched one-hot row/column and key code.
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic              clock_in,
    input  logic              reset_in,
    keypad_scanner_if.master  bus
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {S_IDLE, S_CAND, S_PRESS, S_REL} state_t;

    logic [2:0]       r_sync1, r_sync2;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_row;
    logic [3:0]       r_row_drive;
    logic [3:0][2:0]  r_acc;          // one column sample per row, overwritten each sweep
    logic             r_sweep_done;   // high on the clock after the row-3 sample

    state_t           r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt, w_next_cnt, w_cnt_inc;
    logic [1:0]       r_cand_row, w_next_cand_row;
    logic [2:0]       r_cand_col, w_next_cand_col;

    logic [2:0]       r_coluna;
    logic [3:0]       r_linha;
    logic             r_valid, r_strobe;
    logic [3:0]       r_code;

    logic [3:0]       w_nbits;
    logic [1:0]       w_key_row, w_row_nxt, w_col_idx;
    logic [2:0]       w_key_col;
    logic [3:0]       w_key_code;
    logic             w_empty, w_single, w_same;
    logic             w_load, w_clear;

    assign w_row_nxt = r_row + 2'd1;

    // Column synchronizer and row scan: dwell, sample, advance
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_div        <= '0;
            r_row        <= '0;
            r_row_drive  <= 4'b1000;
            r_acc        <= '0;
            r_sweep_done <= 1'b0;
        end else begin
            r_sync1      <= bus.col_sense_in;
            r_sync2      <= r_sync1;
            r_sweep_done <= 1'b0;
            if (r_div == DIV_W'(SCAN_DIV - 1)) begin
                r_div        <= '0;
                r_acc[r_row] <= r_sync2;
                r_row        <= w_row_nxt;
                r_row_drive  <= 4'b1000 >> w_row_nxt;
                r_sweep_done <= (r_row == 2'd3);
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    // Classify the completed sweep; with exactly one bit set, row/col name the key
    always_comb begin
        w_nbits   = '0;
        w_key_row = '0;
        w_key_col = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++)
                if (r_acc[r][c]) w_nbits = w_nbits + 4'd1;
            if (r_acc[r] != 3'b000) begin
                w_key_row = 2'(r);
                w_key_col = r_acc[r];
            end
        end
        case (w_key_col)
            3'b100:  w_col_idx = 2'd0;
            3'b010:  w_col_idx = 2'd1;
            default: w_col_idx = 2'd2;
        endcase
    end

    assign w_empty    = (w_nbits == 4'd0);
    assign w_single   = (w_nbits == 4'd1);
    assign w_same     = (w_key_row == r_cand_row) && (w_key_col == r_cand_col);
    assign w_key_code = {2'b00, w_key_row} * 4'd3 + {2'b00, w_col_idx} + 4'd1;
    assign w_cnt_inc  = (r_cnt >= CNT_MAX) ? CNT_MAX : r_cnt + CNT_W'(1);

    // FSM state register
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_cand_row <= '0;
            r_cand_col <= '0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            r_cand_row <= w_next_cand_row;
            r_cand_col <= w_next_cand_col;
        end
    end

    // FSM next state: evaluated once per sweep
    always_comb begin
        w_next_state    = r_state;
        w_next_cnt      = r_cnt;
        w_next_cand_row = r_cand_row;
        w_next_cand_col = r_cand_col;
        if (r_sweep_done) begin
            case (r_state)
                S_IDLE: if (w_single) begin
                    w_next_cand_row = w_key_row;
                    w_next_cand_col = w_key_col;
                    w_next_cnt      = CNT_W'(1);
                    w_next_state    = (DEBOUNCE_CNT == 1) ? S_PRESS : S_CAND;
                end
                S_CAND: begin
                    if (w_single && w_same) begin
                        w_next_cnt = w_cnt_inc;
                        if (w_cnt_inc == CNT_MAX) w_next_state = S_PRESS;
                    end else if (w_single) begin
                        w_next_cand_row = w_key_row;
                        w_next_cand_col = w_key_col;
                        w_next_cnt      = CNT_W'(1);
                        if (DEBOUNCE_CNT == 1) w_next_state = S_PRESS;
                    end else begin
                        w_next_cnt   = '0;
                        w_next_state = S_IDLE;
                    end
                end
                S_PRESS: if (w_empty) begin
                    if (DEBOUNCE_CNT == 1) begin
                        w_next_cnt   = '0;
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_cnt   = CNT_W'(1);
                        w_next_state = S_REL;
                    end
                end
                default: begin // S_REL
                    if (w_empty) begin
                        w_next_cnt = w_cnt_inc;
                        if (w_cnt_inc == CNT_MAX) begin
                            w_next_cnt   = '0;
                            w_next_state = S_IDLE;
                        end
                    end else begin
                        w_next_state = S_PRESS;
                    end
                end
            endcase
        end
    end

    // FSM outputs: latch on fresh acceptance, clear on return to idle
    always_comb begin
        w_load  = (w_next_state == S_PRESS) && ((r_state == S_IDLE) || (r_state == S_CAND));
        w_clear = (w_next_state == S_IDLE) && ((r_state == S_PRESS) || (r_state == S_REL));
    end

    // Registered key outputs and one-clock accept strobe
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_coluna <= '0;
            r_linha  <= '0;
            r_valid  <= 1'b0;
            r_strobe <= 1'b0;
            r_code   <= '0;
        end else begin
            r_strobe <= w_load;
            if (w_load) begin
                r_coluna <= w_key_col;
                r_linha  <= 4'b1000 >> w_key_row;
                r_valid  <= 1'b1;
                r_code   <= w_key_code;
            end else if (w_clear) begin
                r_coluna <= '0;
                r_linha  <= '0;
                r_valid  <= 1'b0;
                r_code   <= '0;
            end
        end
    end

    assign bus.row_drive_out  = r_row_drive;
    assign bus.coluna_out     = r_coluna;
    assign bus.linha_out      = r_linha;
    assign bus.key_valid_out  = r_valid;
    assign bus.key_strobe_out = r_strobe;
    assign bus.key_code_out   = r_code;
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed sweep table, latency/reset
// sequences, and randomized sweeps against a sweep-level reference model.
module tb_keypad_scanner;
    localparam int SD    = 4;
    localparam int DB    = 2;
    localparam int SWEEP = 4 * SD;

    logic        clock_in = 1'b0;
    logic        reset_in = 1'b0;
    logic [11:0] keys     = '0;   // bit k = key code k+1 held
    logic [2:0]  w_col;

    keypad_scanner_if bus();

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .bus      (bus.master)
    );

    always #5 clock_in = ~clock_in;

    // Keypad matrix: column c reads high while row r is driven and key (r,c) is held
    always_comb begin
        w_col = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (keys[r*3+c] && bus.row_drive_out[3-r]) w_col[2-c] = 1'b1;
    end
    assign bus.col_sense_in = w_col;

    int errors = 0;
    int checks = 0;
    int strobes = 0;

    always @(posedge clock_in) begin
        #1;
        if (bus.key_strobe_out) strobes++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] K(input int n);
        return 12'(1) << (n - 1);
    endfunction

    function automatic logic [12:0] obs();
        return {bus.key_valid_out, bus.key_strobe_out, bus.key_code_out, bus.coluna_out, bus.linha_out};
    endfunction

    // {valid, strobe, code, coluna, linha} expected for a given held code
    function automatic logic [12:0] exp_pack(input int code, input bit stb);
        logic [2:0] col;
        logic [3:0] lin;
        if (code == 0) return {1'b0, stb, 11'd0};
        col = 3'b100 >> ((code - 1) % 3);
        lin = 4'b1000 >> ((code - 1) / 3);
        return {1'b1, stb, 4'(code), col, lin};
    endfunction

    // Sweep-level reference model: one step per completed sweep
    int m_state, m_cand, m_cnt, m_code;
    bit m_strobe;

    task automatic model_reset();
        m_state = 0; m_cand = 0; m_cnt = 0; m_code = 0; m_strobe = 0;
    endtask

    task automatic model_step(input logic [11:0] k);
        int n, key;
        n = $countones(k);
        key = 0;
        for (int i = 0; i < 12; i++) if (k[i]) key = i;
        m_strobe = 0;
        case (m_state)
            0: if (n == 1) begin
                m_cand = key; m_cnt = 1; m_state = 1;
                if (m_cnt >= DB) begin m_state = 2; m_code = key + 1; m_strobe = 1; end
            end
            1: if (n == 1) begin
                if (key == m_cand) m_cnt++;
                else begin m_cand = key; m_cnt = 1; end
                if (m_cnt >= DB) begin m_state = 2; m_code = key + 1; m_strobe = 1; end
            end else begin
                m_state = 0; m_cnt = 0;
            end
            2: if (n == 0) begin
                m_cnt = 1; m_state = 3;
                if (m_cnt >= DB) begin m_state = 0; m_code = 0; end
            end
            default: if (n == 0) begin
                m_cnt++;
                if (m_cnt >= DB) begin m_state = 0; m_code = 0; m_cnt = 0; end
            end else m_state = 2;
        endcase
    endtask

    // Leaves reset released at the negedge after the reset edge
    task automatic do_reset();
        @(negedge clock_in);
        reset_in = 1'b1;
        @(negedge clock_in);
        reset_in = 1'b0;
    endtask

    typedef struct {
        logic [11:0] k;
        int          code;
        bit          stb;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [11:0] k, input int code, input bit stb);
        tbl.push_back('{k, code, stb});
    endtask

    task automatic wait_strobe(input string name);
        bit found = 0;
        for (int i = 0; i < 52 && !found; i++) begin
            @(negedge clock_in);
            if (bus.key_strobe_out) found = 1;
        end
        check(name, 32'(found), 32'd1);
    endtask

    initial begin
        // sweep-by-sweep directed table: keys held for a sweep -> outputs after it
        add(K(5), 0, 0);  add(K(5), 5, 1);  add(K(5), 5, 0);
        add('0, 5, 0);    add(K(5), 5, 0);                 // one-sweep release glitch
        add('0, 5, 0);    add('0, 0, 0);
        add(K(1) | K(9), 0, 0); add(K(1) | K(9), 0, 0);
        add(K(1), 0, 0);  add(K(1), 1, 1);  add('0, 1, 0);  add('0, 0, 0);
        add(K(3), 0, 0);  add('0, 0, 0);                   // held one sweep only
        add(K(3), 0, 0);  add(K(6), 0, 0);  add(K(3), 0, 0);  add(K(6), 0, 0);
        add(K(12), 0, 0); add(K(12), 12, 1); add(K(9), 12, 0);
        add('0, 12, 0);   add('0, 0, 0);

        // reset state and idle row scan
        keys = '0;
        do_reset();
        check("reset_state", {19'd0, bus.row_drive_out, obs()}, {19'd0, 4'b1000, 13'd0});
        for (int n = 1; n <= 64; n++) begin
            @(negedge clock_in);
            check("idle_scan", {19'd0, bus.row_drive_out, obs()},
                  {19'd0, 4'(4'b1000 >> ((n / SD) % 4)), 13'd0});
        end

        // directed table
        do_reset();
        @(negedge clock_in);
        for (int i = 0; i < tbl.size(); i++) begin
            int s0;
            keys = tbl[i].k;
            s0 = strobes;
            repeat (SWEEP) @(negedge clock_in);
            check($sformatf("tbl[%0d]", i), 32'(obs()), 32'(exp_pack(tbl[i].code, tbl[i].stb)));
            check($sformatf("tbl_strobes[%0d]", i), 32'(strobes - s0), 32'(tbl[i].stb));
        end

        // press latency from an arbitrary phase, then reset while pressed
        keys = '0;
        do_reset();
        repeat ($urandom_range(0, 15)) @(negedge clock_in);
        keys = K(5);
        wait_strobe("press_latency");
        check("press_outputs", 32'(obs()), 32'(exp_pack(5, 1)));
        repeat (20) @(negedge clock_in);
        check("press_held", 32'(obs()), 32'(exp_pack(5, 0)));
        reset_in = 1'b1;
        @(negedge clock_in);
        check("reset_in_press", {19'd0, bus.row_drive_out, obs()}, {19'd0, 4'b1000, 13'd0});
        reset_in = 1'b0;
        wait_strobe("reaccept_after_reset");
        check("reaccept_outputs", 32'(obs()), 32'(exp_pack(5, 1)));

        // randomized sweeps against the reference model
        keys = '0;
        do_reset();
        model_reset();
        @(negedge clock_in);
        for (int i = 0; i < 80; i++) begin
            int sel, s0;
            logic [11:0] nk;
            sel = int'($urandom_range(0, 9));
            nk = keys;
            if (sel < 2) nk = '0;
            else if (sel < 6) nk = keys;
            else if (sel < 9) nk = K(int'($urandom_range(1, 12)));
            else nk = K(int'($urandom_range(1, 6))) | K(int'($urandom_range(7, 12)));
            keys = nk;
            model_step(nk);
            s0 = strobes;
            repeat (SWEEP) @(negedge clock_in);
            check($sformatf("rand[%0d]", i), 32'(obs()), 32'(exp_pack(m_code, m_strobe)));
            check($sformatf("rand_strobes[%0d]", i), 32'(strobes - s0), 32'(m_strobe));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
